// File: rtl/lock_pkg.sv
// Shared types and width helper for the attempt lockout controller.
package lock_pkg;

    // Controller states: accepting attempts, or refusing them while a timer runs.
    typedef enum logic {
        ARMED  = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    // Bits needed to hold every value 0..max_value (never less than one bit).
    function automatic int cnt_width(input longint unsigned max_value);
        int w;
        w = 1;
        while ((64'd1 << w) <= max_value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector for a synchronous level input. The history flop
// resets high so a level already asserted when reset releases is not an event.
module edge_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev_r;

    // Keep last cycle's sample of the input; updated every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= din;
        end
    end

    assign rise = din & ~prev_r;

endmodule

// File: rtl/attempt_lockout_ctrl.sv
// Failed-attempt lockout controller: counts consecutive failed attempts,
// locks out for a (optionally escalating) number of cycles once the limit
// is reached, and supports an administrative master clear.
module attempt_lockout_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCK_CYCLES = 100,
    parameter int unsigned ESCALATE    = 1,
    parameter int unsigned MAX_LEVEL   = 3,
    localparam int CW = cnt_width(longint'(MAX_TRIES)),
    localparam int TW = cnt_width(longint'(LOCK_CYCLES) << MAX_LEVEL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          attempt_fail,
    input  logic          attempt_ok,
    input  logic          admin_clear,
    output logic [CW-1:0] fail_count,
    output logic          locked,
    output logic [TW-1:0] lock_remaining,
    output logic [2:0]    lock_level,
    output logic          lock_event
);

    localparam logic [CW:0]   MAX_TRIES_C = (CW+1)'(MAX_TRIES);
    localparam logic [CW:0]   FAIL_ONE    = (CW+1)'(1'b1);
    localparam logic [TW-1:0] LOCK_BASE   = TW'(LOCK_CYCLES);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1'b1);
    localparam logic [2:0]    MAX_LEVEL_C = 3'(MAX_LEVEL);

    lock_state_t   state_r, state_s;
    logic [CW-1:0] fail_count_r, fail_count_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [2:0]    lock_level_r, lock_level_s;
    logic          locked_r, locked_s;
    logic          lock_event_r, lock_event_s;
    logic [CW:0]   fail_inc_s;
    logic [TW-1:0] lock_load_s;
    logic          fail_rise_s, ok_rise_s;

    edge_rise_det u_fail_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (attempt_fail),
        .rise (fail_rise_s)
    );

    edge_rise_det u_ok_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (attempt_ok),
        .rise (ok_rise_s)
    );

    // Next-state and next-output decode; admin_clear overrides everything.
    always_comb begin
        state_s      = state_r;
        fail_count_s = fail_count_r;
        timer_s      = timer_r;
        lock_level_s = lock_level_r;
        lock_event_s = 1'b0;
        fail_inc_s   = {1'b0, fail_count_r} + FAIL_ONE;
        if (ESCALATE != 0) begin
            lock_load_s = LOCK_BASE << lock_level_r;
        end else begin
            lock_load_s = LOCK_BASE;
        end

        if (admin_clear) begin
            state_s      = ARMED;
            fail_count_s = {CW{1'b0}};
            timer_s      = {TW{1'b0}};
            lock_level_s = 3'd0;
        end else begin
            case (state_r)
                ARMED: begin
                    if (fail_rise_s) begin
                        if (fail_inc_s == MAX_TRIES_C) begin
                            state_s      = LOCKED;
                            timer_s      = lock_load_s;
                            lock_event_s = 1'b1;
                            fail_count_s = {CW{1'b0}};
                            if (ESCALATE == 0) begin
                                lock_level_s = 3'd0;
                            end else if (lock_level_r < MAX_LEVEL_C) begin
                                lock_level_s = lock_level_r + 3'd1;
                            end else begin
                                lock_level_s = MAX_LEVEL_C;
                            end
                        end else begin
                            fail_count_s = fail_inc_s[CW-1:0];
                        end
                    end else if (ok_rise_s) begin
                        fail_count_s = {CW{1'b0}};
                        lock_level_s = 3'd0;
                    end else begin
                        fail_count_s = fail_count_r;
                    end
                end
                LOCKED: begin
                    // Leaving on the edge where the timer reads 1 keeps
                    // locked high for exactly the loaded number of cycles.
                    if (timer_r <= TIMER_ONE) begin
                        state_s = ARMED;
                        timer_s = {TW{1'b0}};
                    end else begin
                        timer_s = timer_r - TIMER_ONE;
                    end
                end
                default: begin
                    state_s      = ARMED;
                    fail_count_s = {CW{1'b0}};
                    timer_s      = {TW{1'b0}};
                    lock_level_s = 3'd0;
                end
            endcase
        end

        locked_s = (state_s == LOCKED);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ARMED;
            fail_count_r <= {CW{1'b0}};
            timer_r      <= {TW{1'b0}};
            lock_level_r <= 3'd0;
            locked_r     <= 1'b0;
            lock_event_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            fail_count_r <= fail_count_s;
            timer_r      <= timer_s;
            lock_level_r <= lock_level_s;
            locked_r     <= locked_s;
            lock_event_r <= lock_event_s;
        end
    end

    assign fail_count     = fail_count_r;
    assign locked         = locked_r;
    assign lock_remaining = timer_r;
    assign lock_level     = lock_level_r;
    assign lock_event     = lock_event_r;

endmodule
